mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter EXP_MISALIGN, default 3'h4, meaning exception code for a misaligned load/store.
REQ-002 SHALL have ports (name direction width meaning):
- cpu_clk  in  1  sole clock, rising edge
- cpu_rst  in  1  reset, synchronous, active-high
- stall  in  1  pipeline stall from controller
- flush  in  1  pipeline flush from controller
- ex_pc/ex_en/ex_br_flag  in  30/1/1  EX stage PC, valid, branch flag
- ex_mem_op  in  2  0 none, 1 load word, 2 store word, 3 treated as none
- ex_mem_wdata  in  32  store data
- ex_ctrl_op/ex_dst_addr/ex_gpr_wen/ex_exp_code  in  2/5/1/3  passthrough controls
- ex_out  in  32  ALU result / byte address
- bus_req  out  1  bus request to arbiter
- bus_grnt  in  1  bus grant
- bus_as  out  1  address strobe, one cycle
- bus_rw  out  1  1 read, 0 write
- bus_addr  out  30  word address = ex_out[31:2]
- bus_wdata  out  32  write data
- bus_rdata  in  32  read data, valid with bus_rdy
- bus_rdy  in  1  transfer complete
- busy  out  1  MEM stage occupied; controller stalls pipeline
- mem_pc/mem_en/mem_br_flag/mem_ctrl_op/mem_dst_addr/mem_gpr_wen/mem_exp_code/mem_out  out  30/1/1/2/5/1/3/32  registered MEM stage outputs

Function
REQ-003 Access pending = ex_en=1, ex_mem_op in {1,2}, ex_exp_code=0, ex_out[1:0]=0, flush=0.
REQ-004 FSM states IDLE, REQ, ACCESS, WAIT; reset state IDLE.
REQ-005 IDLE: access pending -> bus_req=1, busy=1, next REQ; else busy=0, stay.
REQ-006 REQ: bus_req=1, busy=1; flush=1 -> IDLE, bus_req=0 next cycle, no strobe; else bus_grnt=1 -> bus_as=1 same cycle with bus_addr/bus_rw/bus_wdata from ex_*, next ACCESS.
REQ-007 ACCESS: bus_req=1, bus_as=0, bus_addr/bus_rw/bus_wdata held, busy=1; bus_rdy=1 -> latch bus_rdata into rd_buf, next WAIT.
REQ-008 Flush during ACCESS SHALL NOT abort the bus transfer; a discard flag is set and the result is dropped in WAIT.
REQ-009 WAIT: bus_req=0, busy=0; stall=0 -> IDLE; else stay.
REQ-010 bus_addr/bus_wdata/bus_rw SHALL be 0 outside REQ-with-grant and ACCESS.
REQ-011 mem_* SHALL update only when stall=0 and busy=0; otherwise hold.
REQ-012 Update priority: flush or discard flag -> all mem_* 0; ex_exp_code!=0 -> copy pc/en/br_flag/exp_code, other fields 0; misaligned load/store (ex_en=1) -> copy pc/en/br_flag, mem_exp_code=EXP_MISALIGN, gpr_wen=0, others 0; load -> mem_out=rd_buf, rest copied; otherwise all copied, mem_out=ex_out.
REQ-013 Store and none: mem_out=ex_out; store SHALL force mem_gpr_wen unchanged from ex_gpr_wen.
REQ-014 Discard flag clears on leaving WAIT.
REQ-015 No combinational path bus_rdy -> busy; busy is a function of state and ex_* only.

Reset
REQ-016 cpu_rst=1 at a clock edge SHALL force IDLE, clear rd_buf and discard flag, all mem_* = 0, bus_req=bus_as=0; overrides stall/flush.
REQ-017 Reset mid-ACCESS SHALL drop bus_req next cycle; bus transfer not completed.

Verification
REQ-018 Load ex_out=0x100, grant after 2 cycles, rdy after 3, bus_rdata=0xDEADBEEF -> bus_as one pulse, bus_addr=0x40, bus_rw=1; mem_out=0xDEADBEEF one cycle after WAIT entry with stall=0.
REQ-019 Store ex_out=0x24, wdata=0x12345678, immediate grant/rdy -> bus_rw=0, bus_addr=0x9, bus_wdata=0x12345678, mem_out=0x24.
REQ-020 Load ex_out=0x102 -> no bus_req, busy=0, mem_exp_code=4, mem_gpr_wen=0, mem_out=0.
REQ-021 Flush in REQ before grant -> bus_as never asserted, mem_* all 0; flush in ACCESS -> transfer completes, mem_* all 0.
REQ-022 WAIT with stall=1 for 4 cycles -> mem_* unchanged, no second bus_req; stall drop -> mem_out=rd_buf.
REQ-023 cpu_rst during ACCESS -> next cycle bus_req=0, busy=0, all mem_* 0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage: drives a request/grant/strobe bus for aligned word loads
// and stores, and registers the stage outputs toward write-back.
module mem_stage #(
  parameter logic [2:0] EXP_MISALIGN = 3'h4
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] ex_pc,
  input  logic        ex_en,
  input  logic        ex_br_flag,
  input  logic [1:0]  ex_mem_op,
  input  logic [31:0] ex_mem_wdata,
  input  logic [1:0]  ex_ctrl_op,
  input  logic [4:0]  ex_dst_addr,
  input  logic        ex_gpr_wen,
  input  logic [2:0]  ex_exp_code,
  input  logic [31:0] ex_out,
  output logic        bus_req,
  input  logic        bus_grnt,
  output logic        bus_as,
  output logic        bus_rw,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rdy,
  output logic        busy,
  output logic [29:0] mem_pc,
  output logic        mem_en,
  output logic        mem_br_flag,
  output logic [1:0]  mem_ctrl_op,
  output logic [4:0]  mem_dst_addr,
  output logic        mem_gpr_wen,
  output logic [2:0]  mem_exp_code,
  output logic [31:0] mem_out
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic        discard_q, discard_d;
  logic [29:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [31:0] wdata_q, wdata_d;

  logic [29:0] pc_q, pc_d;
  logic        en_q, en_d;
  logic        br_q, br_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [4:0]  dst_q, dst_d;
  logic        wen_q, wen_d;
  logic [2:0]  exp_q, exp_d;
  logic [31:0] out_q, out_d;

  logic is_ls;
  logic is_load;
  logic aligned;
  logic pending;
  logic upd;

  always_comb begin
    is_ls   = (ex_mem_op == 2'd1) || (ex_mem_op == 2'd2);
    is_load = (ex_mem_op == 2'd1);
    aligned = (ex_out[1:0] == 2'b00);
    pending = ex_en && is_ls && (ex_exp_code == 3'd0)
              && aligned && !flush;

    state_d   = state_q;
    rd_buf_d  = rd_buf_q;
    discard_d = discard_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    bus_req   = 1'b0;
    bus_as    = 1'b0;
    bus_rw    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pending) begin
          bus_req = 1'b1;
          busy    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else if (bus_grnt) begin
          bus_as    = 1'b1;
          bus_addr  = ex_out[31:2];
          bus_rw    = is_load;
          bus_wdata = ex_mem_wdata;
          addr_d    = ex_out[31:2];
          rw_d      = is_load;
          wdata_d   = ex_mem_wdata;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        bus_req   = 1'b1;
        busy      = 1'b1;
        bus_addr  = addr_q;
        bus_rw    = rw_q;
        bus_wdata = wdata_q;
        // A flush cannot abort an in-flight transfer; drop it later.
        if (flush) discard_d = 1'b1;
        if (bus_rdy) begin
          rd_buf_d = bus_rdata;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (!stall) begin
          discard_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    upd    = !stall && !busy;
    pc_d   = pc_q;
    en_d   = en_q;
    br_d   = br_q;
    ctrl_d = ctrl_q;
    dst_d  = dst_q;
    wen_d  = wen_q;
    exp_d  = exp_q;
    out_d  = out_q;
    if (upd) begin
      pc_d   = ex_pc;
      en_d   = ex_en;
      br_d   = ex_br_flag;
      ctrl_d = ex_ctrl_op;
      dst_d  = ex_dst_addr;
      wen_d  = ex_gpr_wen;
      exp_d  = ex_exp_code;
      out_d  = ex_out;
      if (flush || discard_q) begin
        pc_d   = '0;
        en_d   = 1'b0;
        br_d   = 1'b0;
        ctrl_d = '0;
        dst_d  = '0;
        wen_d  = 1'b0;
        exp_d  = '0;
        out_d  = '0;
      end else if (ex_exp_code != 3'd0) begin
        ctrl_d = '0;
        dst_d  = '0;
        wen_d  = 1'b0;
        out_d  = '0;
      end else if (ex_en && is_ls && !aligned) begin
        ctrl_d = '0;
        dst_d  = '0;
        wen_d  = 1'b0;
        exp_d  = EXP_MISALIGN;
        out_d  = '0;
      end else if (is_load) begin
        out_d = rd_buf_q;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q   <= IDLE;
      rd_buf_q  <= '0;
      discard_q <= 1'b0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      pc_q      <= '0;
      en_q      <= 1'b0;
      br_q      <= 1'b0;
      ctrl_q    <= '0;
      dst_q     <= '0;
      wen_q     <= 1'b0;
      exp_q     <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_buf_q  <= rd_buf_d;
      discard_q <= discard_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      pc_q      <= pc_d;
      en_q      <= en_d;
      br_q      <= br_d;
      ctrl_q    <= ctrl_d;
      dst_q     <= dst_d;
      wen_q     <= wen_d;
      exp_q     <= exp_d;
      out_q     <= out_d;
    end
  end

  assign mem_pc       = pc_q;
  assign mem_en       = en_q;
  assign mem_br_flag  = br_q;
  assign mem_ctrl_op  = ctrl_q;
  assign mem_dst_addr = dst_q;
  assign mem_gpr_wen  = wen_q;
  assign mem_exp_code = exp_q;
  assign mem_out      = out_q;

endmodule
